divu_seq: RTL and testbench
===========================

DIVU_SEQ -- requirements
Module: divu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request; launches an operation when the block is idle or done.
REQ-005 SHALL have port is_rem  input  1  result select: 0 = quotient (DIVU/DIV), 1 = remainder (REMU/REM).
REQ-006 SHALL have port A  input  WIDTH  dividend, sampled only on an accepted start.
REQ-007 SHALL have port B  input  WIDTH  divisor, sampled only on an accepted start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking Y valid.
REQ-010 SHALL have port Y  output  WIDTH  result; held stable from done until the next accepted start.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-012 SHALL accept start in IDLE or DONE only, and SHALL ignore start in BUSY.
REQ-013 SHALL on an accepted start latch A, B and is_rem, clear the remainder accumulator, load the iteration counter with WIDTH-1, and go to BUSY.
REQ-014 SHALL in each BUSY cycle perform one restoring step: shift {rem, dividend} left 1; if rem >= B (unsigned), subtract B and set quotient bit 1, else set it 0.
REQ-015 SHALL leave BUSY after exactly WIDTH steps, enter DONE, assert done for that one cycle and drive Y.
REQ-016 SHALL give latency start-edge to done of WIDTH+1 cycles (33 for WIDTH = 32).
REQ-017 SHALL go from DONE to IDLE when start is low, or back to BUSY when start is high (back-to-back issue, no bubble).
REQ-018 SHALL for B == 0 skip iteration and enter DONE on the next edge (latency 1) with quotient = all ones and remainder = A.
REQ-019 SHALL hold busy = 1 in BUSY only; done = 1 in DONE only.
REQ-020 SHALL not change Y in IDLE or BUSY; Y changes only on entry to DONE.

Reset
REQ-021 SHALL on rst_n low, at any time including mid-operation, force IDLE, busy = 0, done = 0, Y = 0, and clear all internal datapath registers.
REQ-022 SHALL ignore start in the first rising edge on which rst_n is sampled high after release.

Configuration
REQ-023 SHALL with macro DIVU_SEQ_SIGNED_EN defined add input op_signed (1 bit); when it is high, operands are converted to magnitudes at start, the quotient is negated if the signs differ, and the remainder takes the dividend's sign.
REQ-024 SHALL with DIVU_SEQ_SIGNED_EN defined and op_signed high: B == 0 gives quotient -1 and remainder A; A = most-negative with B = -1 gives quotient = A and remainder = 0, both with latency 1.
REQ-025 SHALL without DIVU_SEQ_SIGNED_EN have no op_signed port and unsigned-only behaviour.

Structure
REQ-026 SHALL take the FSM state enumeration and the default WIDTH constant from shared package alu_pkg.
REQ-027 SHALL implement one restoring iteration as combinational sub-module div_step (inputs rem, dividend MSB, B; outputs next rem, quotient bit).

Verification
REQ-028 SHALL cover: A = 100, B = 7, is_rem = 0 -> done after 33 cycles, Y = 14; same with is_rem = 1 -> Y = 2.
REQ-029 SHALL cover: A = 0xFFFFFFFF, B = 1 -> Y = 0xFFFFFFFF (quotient); A = 5, B = 9 -> quotient 0, remainder 5.
REQ-030 SHALL cover: B = 0, A = 0x1234 -> done 1 cycle after start, quotient = 0xFFFFFFFF, remainder = 0x1234.
REQ-031 SHALL cover: start pulsed mid-BUSY with new operands -> ignored, original result returned; start held in DONE -> next result 33 cycles later.
REQ-032 SHALL cover: rst_n low at step 10 -> busy = 0, Y = 0 immediately; after release, a new operation completes correctly.
REQ-033 SHALL cover, under DIVU_SEQ_SIGNED_EN: A = -7, B = 2 -> quotient -3, remainder -1; A = 0x80000000, B = -1 -> quotient 0x80000000, remainder 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: the divider FSM state encoding and the default datapath width.
package alu_pkg;

  localparam int DIVU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  // The shifted remainder can reach 2*B-1, so compare and subtract on WIDTH+1 bits.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtraction; keep the difference only when the divisor fits.
  always_comb begin
    shifted = {rem_i, msb_i};
    diff    = shifted - {1'b0, b_i};
    q_o     = (shifted >= {1'b0, b_i});
    rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divu_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// Define DIVU_SEQ_SIGNED_EN to add the op_signed input for signed DIV/REM.
module divu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DIVU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_rem,
`ifdef DIVU_SEQ_SIGNED_EN
  input  logic             op_signed,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifts out MSB-first, quotient shifts in
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             armed_q;          // low for the first edge after reset release

  logic             sgn;
  logic             neg_a, neg_b, ovf;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] step_rem, quo_next;
  logic             step_q;

`ifdef DIVU_SEQ_SIGNED_EN
  assign sgn = op_signed;
`else
  assign sgn = 1'b0;
`endif

  // Operand sign handling at issue time; unsigned builds see sgn tied low.
  always_comb begin
    neg_a = sgn & A[WIDTH-1];
    neg_b = sgn & B[WIDTH-1];
    mag_a = neg_a ? (~A + 1'b1) : A;
    mag_b = neg_b ? (~B + 1'b1) : B;
    ovf   = sgn && (A == MOST_NEG) && (B == '1);
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .msb_i (dvd_q[WIDTH-1]),
    .b_i   (b_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  assign quo_next = {dvd_q[WIDTH-2:0], step_q};

  // Next-state and datapath update; Y is only written when entering DONE.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    y_d       = y_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start && armed_q) begin
          is_rem_d  = is_rem;
          rem_d     = '0;
          cnt_d     = CNT_MAX;
          dvd_d     = mag_a;
          b_d       = mag_b;
          neg_quo_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          if (B == '0) begin
            // Divide by zero: quotient all ones, remainder is the dividend.
            state_d = DONE;
            y_d     = is_rem ? A : '1;
          end else if (ovf) begin
            // Signed overflow: quotient wraps to the dividend, remainder zero.
            state_d = DONE;
            y_d     = is_rem ? '0 : A;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = step_rem;
        dvd_d = quo_next;
        if (cnt_q == '0) begin
          state_d = DONE;
          if (is_rem_q) y_d = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
          else          y_d = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == BUSY);
    done_d = (state_d == DONE);
  end

  // State, datapath and registered status outputs, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      dvd_q     <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      y_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      y_q       <= y_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      armed_q   <= 1'b1;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Y    = y_q;

endmodule

// File: tb/tb_divu_seq.sv
// Directed testbench for divu_seq (WIDTH = 32); signed cases need DIVU_SEQ_SIGNED_EN.
module tb_divu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_rem = 1'b0;
  logic        op_signed = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic        done;
  logic [31:0] Y;

  int checks = 0;
  int errors = 0;

  divu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_rem    (is_rem),
`ifdef DIVU_SEQ_SIGNED_EN
    .op_signed (op_signed),
`endif
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .Y         (Y)
  );

  always #5 clk = ~clk;

  // Issue one operation from the current time (away from an edge) and wait for done.
  // lat counts rising edges from the accepting edge (inclusive) to the one raising done.
  // A nonzero poke_at pulses start with other operands one edge after that count.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic r,
                        input int poke_at, output logic [31:0] y, output int lat);
    A = a; B = b; is_rem = r; start = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    start = 1'b0;
    while (!done && lat < 100) begin
      if (lat == poke_at) begin
        A = 32'd1000; B = 32'd3; is_rem = ~r; start = 1'b1;
      end
      @(posedge clk);
      lat++;
      #1;
      start = 1'b0;
    end
    y = Y;
    $display("op A=%08h B=%08h rem=%0d -> Y=%08h latency=%0d", a, b, r, y, lat);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (Y !== 32'h0) begin errors++; $display("FAIL reset_y: got %08h want 00000000", Y); end
    // Start on the very first edge after release must be ignored.
    @(negedge clk);
    rst_n = 1'b1; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL first_edge_ignore: busy %b want 0", busy); end
    $display("reset: outputs clear, first-edge start ignored");
  endtask

  task automatic test_basic();
    logic [31:0] y;
    int lat;
    run_op(32'd100, 32'd7, 1'b0, 0, y, lat);
    checks++;
    if (y !== 32'd14) begin errors++; $display("FAIL quo_100_7: got %0d want 14", y); end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL lat_100_7: got %0d want 33", lat); end
    // Result must hold through idle cycles.
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Y !== 32'd14 || done !== 1'b0) begin
      errors++; $display("FAIL y_hold_idle: Y %0d done %b want 14 / 0", Y, done);
    end
    run_op(32'd100, 32'd7, 1'b1, 0, y, lat);
    checks++;
    if (y !== 32'd2) begin errors++; $display("FAIL rem_100_7: got %0d want 2", y); end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL lat_rem_100_7: got %0d want 33", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [31:0] y;
    int lat;
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, y, lat);
    checks++;
    if (y !== 32'hFFFF_FFFF) begin errors++; $display("FAIL quo_max_1: got %08h want ffffffff", y); end
    @(posedge clk); #1;
    run_op(32'hFFFF_FFFF, 32'd1, 1'b1, 0, y, lat);
    checks++;
    if (y !== 32'h0) begin errors++; $display("FAIL rem_max_1: got %08h want 0", y); end
    @(posedge clk); #1;
    run_op(32'd5, 32'd9, 1'b0, 0, y, lat);
    checks++;
    if (y !== 32'd0) begin errors++; $display("FAIL quo_5_9: got %0d want 0", y); end
    @(posedge clk); #1;
    run_op(32'd5, 32'd9, 1'b1, 0, y, lat);
    checks++;
    if (y !== 32'd5) begin errors++; $display("FAIL rem_5_9: got %0d want 5", y); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    logic [31:0] y;
    int lat;
    run_op(32'h1234, 32'd0, 1'b0, 0, y, lat);
    checks++;
    if (y !== 32'hFFFF_FFFF) begin errors++; $display("FAIL quo_div0: got %08h want ffffffff", y); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL lat_quo_div0: got %0d want 1", lat); end
    @(posedge clk); #1;
    run_op(32'h1234, 32'd0, 1'b1, 0, y, lat);
    checks++;
    if (y !== 32'h1234) begin errors++; $display("FAIL rem_div0: got %08h want 00001234", y); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL lat_rem_div0: got %0d want 1", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore();
    logic [31:0] y;
    int lat;
    // 1000 / 3 would give 333 (or rem 1); the original 100 / 7 must win.
    run_op(32'd100, 32'd7, 1'b0, 5, y, lat);
    checks++;
    if (y !== 32'd14) begin errors++; $display("FAIL busy_ignore_y: got %0d want 14", y); end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL busy_ignore_lat: got %0d want 33", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] y;
    int lat;
    run_op(32'd100, 32'd7, 1'b1, 0, y, lat);
    checks++;
    if (y !== 32'd2) begin errors++; $display("FAIL b2b_first: got %0d want 2", y); end
    // Issued while the first result is in DONE: no idle bubble allowed.
    run_op(32'd200, 32'd9, 1'b0, 0, y, lat);
    checks++;
    if (y !== 32'd22) begin errors++; $display("FAIL b2b_second: got %0d want 22", y); end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL b2b_lat: got %0d want 33", lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] y;
    int lat;
    A = 32'd1000; B = 32'd3; is_rem = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset_status: busy %b done %b want 0/0", busy, done);
    end
    checks++;
    if (Y !== 32'h0) begin errors++; $display("FAIL mid_reset_y: got %08h want 0", Y); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(32'd1000, 32'd3, 1'b0, 0, y, lat);
    checks++;
    if (y !== 32'd333) begin errors++; $display("FAIL after_reset_y: got %0d want 333", y); end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL after_reset_lat: got %0d want 33", lat); end
    @(posedge clk); #1;
  endtask

`ifdef DIVU_SEQ_SIGNED_EN
  task automatic test_signed();
    logic [31:0] y;
    int lat;
    op_signed = 1'b1;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 0, y, lat);
    checks++;
    if (y !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_m7_2: got %08h want fffffffd", y); end
    @(posedge clk); #1;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, y, lat);
    checks++;
    if (y !== 32'hFFFF_FFFF) begin errors++; $display("FAIL srem_m7_2: got %08h want ffffffff", y); end
    @(posedge clk); #1;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, y, lat);
    checks++;
    if (y !== 32'h8000_0000 || lat !== 1) begin
      errors++; $display("FAIL sdiv_ovf: got %08h lat %0d want 80000000 lat 1", y, lat);
    end
    @(posedge clk); #1;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, y, lat);
    checks++;
    if (y !== 32'h0 || lat !== 1) begin
      errors++; $display("FAIL srem_ovf: got %08h lat %0d want 0 lat 1", y, lat);
    end
    op_signed = 1'b0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef DIVU_SEQ_SIGNED_EN
    test_signed();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
